// File: rtl/hoop_game_if.sv
// Handshake bundle between the hoop game controller and its surroundings:
// raw button/switch inputs in, registered score/time/status out.
interface hoop_game_if #(
  parameter int SCORE_W = 8
) ();
  logic               start;
  logic               in_switch;
  logic [SCORE_W-1:0] score_count;
  logic [7:0]         time_left;
  logic               playing;
  logic               game_done;

  modport master (
    output start,
    output in_switch,
    input  score_count,
    input  time_left,
    input  playing,
    input  game_done
  );

  modport slave (
    input  start,
    input  in_switch,
    output score_count,
    output time_left,
    output playing,
    output game_done
  );
endinterface

// File: rtl/hoop_game_ctrl.sv
// Timed hoop-shot round controller: synchronises and debounces the hoop switch,
// counts made shots while a round runs, and strobes game_done with the final score.
module hoop_game_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int GAME_SECS    = 10,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SCORE_W      = 8
) (
  input logic        clock,
  input logic        reset,
  hoop_game_if.slave bus
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]         GAME_INIT = 8'(GAME_SECS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PLAYING = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic              start_s1, start_s2, start_prev;
  logic              sw_s1, sw_s2;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_level, deb_prev;
  logic [TICK_W-1:0] tick_cnt;
  logic [1:0]        state;
  logic [SCORE_W-1:0] score_q;
  logic [7:0]        time_q;
  logic              playing_q;
  logic              done_q;

  logic start_edge;
  logic shot_pulse;

  assign start_edge = start_s2 & ~start_prev;
  assign shot_pulse = deb_level & ~deb_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      sw_s1      <= 1'b0;
      sw_s2      <= 1'b0;
    end else begin
      start_s1   <= bus.start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      sw_s1      <= bus.in_switch;
      sw_s2      <= sw_s1;
    end
  end

  // A new switch level is only taken once it has disagreed for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (sw_s2 != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= sw_s2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      score_q   <= '0;
      time_q    <= GAME_INIT;
      tick_cnt  <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state     <= PLAYING;
            score_q   <= '0;
            time_q    <= GAME_INIT;
            tick_cnt  <= '0;
            playing_q <= 1'b1;
          end
        end
        PLAYING: begin
          // A shot landing on the final tick still makes it into the strobed score.
          if (shot_pulse && (score_q != SCORE_MAX)) begin
            score_q <= score_q + 1'b1;
          end
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (time_q > 8'd1) begin
              time_q <= time_q - 8'd1;
            end else begin
              time_q    <= 8'd0;
              state     <= DONE;
              playing_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score_count = score_q;
  assign bus.time_left   = time_q;
  assign bus.playing     = playing_q;
  assign bus.game_done   = done_q;

endmodule
